// File: rtl/regfile_wport_ctrl.sv
// Write-port controller for the 32x32 register file: zero-init sequencer for r1..r31,
// then round-robin arbitration of writeback requesters onto a registered write port.
module regfile_wport_ctrl #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_waddr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  input  logic               clr_req,
  output logic               we,
  output logic [AW-1:0]      waddr,
  output logic [DW-1:0]      wdata,
  output logic               init_busy
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [0:0] {StInit, StArb} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gnt_idx;
  logic            gnt_any;
  logic            xfer;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  int unsigned     cand;

  // Search starts one past the last winner, so the last winner has lowest priority.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = (32'(rr_ptr_q) + k) % NREQ;
      if (!gnt_any && req_valid[PW'(cand)]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(cand);
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  assign xfer      = (state_q == StArb) && !clr_req && gnt_any;
  assign req_ready = xfer ? gnt : '0;
  assign sel_addr  = req_waddr[32'(gnt_idx)*AW +: AW];
  assign sel_data  = req_wdata[32'(gnt_idx)*DW +: DW];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    unique case (state_q)
      StInit: begin
        we_d    = 1'b1;
        waddr_d = cnt_q;
        wdata_d = '0;
        cnt_d   = cnt_q + AW'(1);
        if (cnt_q == '1) begin
          state_d = StArb;
          cnt_d   = AW'(1);
        end
      end
      StArb: begin
        if (clr_req) begin
          state_d = StInit;
          cnt_d   = AW'(1);
        end else if (xfer) begin
          rr_ptr_d = gnt_idx;
          waddr_d  = sel_addr;
          wdata_d  = sel_data;
          // r0 is hardwired zero: accept the request but suppress the write.
          we_d     = (sel_addr != '0);
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StInit;
      cnt_q    <= AW'(1);
      rr_ptr_q <= PW'(NREQ - 1);
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign we        = we_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign init_busy = (state_q == StInit);

endmodule

// File: tb/tb_regfile_wport_ctrl.sv
// Bench for regfile_wport_ctrl: directed scenarios plus randomized traffic, all checked
// against a cycle-level behavioural model of the write port.
module tb_regfile_wport_ctrl;

  localparam int NREQ = 3;
  localparam int DW   = 32;
  localparam int AW   = 5;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*AW-1:0] req_waddr = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic [NREQ-1:0]    req_ready;
  logic               clr_req = 1'b0;
  logic               we;
  logic [AW-1:0]      waddr;
  logic [DW-1:0]      wdata;
  logic               init_busy;

  regfile_wport_ctrl #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_waddr (req_waddr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .clr_req   (clr_req),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: init progress, last winner, and what the port should show.
  bit            m_init;
  int            m_next;
  int            m_ptr;
  bit            e_we;
  int            e_waddr;
  logic [DW-1:0] e_wdata;
  int            last_gnt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_init   = 1'b1;
    m_next   = 1;
    m_ptr    = NREQ - 1;
    e_we     = 1'b0;
    e_waddr  = 0;
    e_wdata  = '0;
    last_gnt = -1;
  endtask

  function automatic logic [NREQ-1:0] model_ready();
    logic [NREQ-1:0] r;
    r = '0;
    if (!m_init && !clr_req) begin
      for (int k = 1; k <= NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (r == '0 && req_valid[i]) r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic model_edge(input logic [NREQ-1:0] rdy);
    last_gnt = -1;
    if (m_init) begin
      e_we    = 1'b1;
      e_waddr = m_next;
      e_wdata = '0;
      if (m_next == 31) begin
        m_init = 1'b0;
        m_next = 1;
      end else begin
        m_next++;
      end
    end else if (clr_req) begin
      m_init = 1'b1;
      m_next = 1;
      e_we   = 1'b0;
    end else begin
      e_we = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (rdy[i]) begin
          last_gnt = i;
          m_ptr    = i;
          e_waddr  = int'(req_waddr[i*AW +: AW]);
          e_wdata  = req_wdata[i*DW +: DW];
          e_we     = (e_waddr != 0);
        end
      end
    end
  endtask

  task automatic check_port(input string tag);
    check_eq({tag, ".we"}, 64'(we), 64'(e_we));
    check_eq({tag, ".waddr"}, 64'(waddr), 64'(e_waddr));
    check_eq({tag, ".wdata"}, 64'(wdata), 64'(e_wdata));
    check_eq({tag, ".busy"}, 64'(init_busy), 64'(m_init));
  endtask

  // Called at posedge+1 with inputs already applied; returns at the next posedge+1.
  task automatic cycle(input string tag);
    logic [NREQ-1:0] rdy;
    rdy = model_ready();
    #3;
    check_eq({tag, ".ready"}, 64'(req_ready), 64'(rdy));
    @(posedge clk);
    model_edge(rdy);
    #1;
    check_port(tag);
  endtask

  task automatic set_req(input int i, input bit v, input int a, input logic [DW-1:0] d);
    req_valid[i]           = v;
    req_waddr[i*AW +: AW]  = AW'(a);
    req_wdata[i*DW +: DW]  = d;
  endtask

  initial begin
    int exp_order[4];
    exp_order = '{0, 1, 2, 0};

    // Reset state, with requesters valid to prove ready is forced low.
    req_valid = '1;
    #1 rst = 1'b0;
    #1;
    model_reset();
    check_eq("rst.ready", 64'(req_ready), 64'(0));
    check_port("rst");
    req_valid = '0;
    @(posedge clk);
    #1 rst = 1'b1;

    // Power-up init: 31 writes r1..r31, then idle.
    repeat (31) cycle("init");
    check_eq("init.end_addr", 64'(waddr), 64'(31));
    cycle("idle0");

    // Full contention: strict rotation 0,1,2,0.
    set_req(0, 1'b1, 5, 32'hAA);
    set_req(1, 1'b1, 6, 32'hBB);
    set_req(2, 1'b1, 7, 32'hCC);
    for (int k = 0; k < 4; k++) begin
      cycle("rr");
      check_eq("rr.order", 64'(last_gnt), 64'(exp_order[k]));
    end
    req_valid = '0;
    cycle("idle1");

    // Lone requester 2, write visible for exactly one cycle.
    set_req(2, 1'b1, 9, 32'h1234);
    cycle("r2");
    check_eq("r2.gnt", 64'(last_gnt), 64'(2));
    req_valid = '0;
    cycle("r2.after");

    // Address-0 write is accepted but suppressed; pointer still advances.
    set_req(1, 1'b1, 0, 32'hFFFF);
    cycle("a0");
    check_eq("a0.gnt", 64'(last_gnt), 64'(1));
    req_valid = '0;
    set_req(0, 1'b1, 3, 32'h30);
    set_req(2, 1'b1, 4, 32'h40);
    cycle("a0.next");
    check_eq("a0.next.gnt", 64'(last_gnt), 64'(2));
    req_valid[2] = 1'b0;
    cycle("a0.last");
    check_eq("a0.last.gnt", 64'(last_gnt), 64'(0));
    req_valid = '0;

    // clr_req while requester 0 waits: full re-init, then requester 0 first.
    set_req(0, 1'b1, 10, 32'h55);
    clr_req = 1'b1;
    cycle("clr");
    clr_req = 1'b0;
    repeat (31) cycle("reinit");
    cycle("clr.post");
    check_eq("clr.post.gnt", 64'(last_gnt), 64'(0));
    req_valid = '0;

    // Async reset in the middle of an init sequence.
    clr_req = 1'b1;
    cycle("clr2");
    clr_req = 1'b0;
    repeat (12) cycle("init2");
    check_eq("mid.addr", 64'(waddr), 64'(12));
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_port("mid.rst");
    @(posedge clk);
    #1 rst = 1'b1;
    cycle("restart");
    check_eq("restart.addr", 64'(waddr), 64'(1));
    repeat (31) cycle("init3");

    // Randomized traffic with occasional clears and r0 writes.
    for (int n = 0; n < 400; n++) begin
      clr_req = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          set_req(i, 1'b1, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 31)),
                  $urandom);
        end
      end
      cycle("rnd");
      if (last_gnt >= 0) req_valid[last_gnt] = 1'b0;
    end
    clr_req = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
